// File: rtl/axis_frame_len_enforce.sv
// axis_frame_len_enforce
// Per-frame byte-length checker/enforcer in front of a frame-mode AXI-Stream FIFO.
// Frames shorter than the minimum are marked bad on tuser[0]. Frames longer than
// the maximum are cut: tlast is forced and tuser[0] is set on the cut beat, and the
// rest of the frame is swallowed. Completed frame lengths and error pulses feed
// the MAC statistics counters.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   s_axis_*                 input stream (tdata, tkeep, tvalid, tready, tlast, tuser)
//   m_axis_*                 output stream, a single register stage
//   cfg_min_len/cfg_max_len  legal length window in bytes (0 disables a bound);
//                            sampled on the first beat of each frame
//   status_frame_len         saturated byte count of the last completed input frame
//   status_frame_len_valid   one-cycle pulse when status_frame_len is updated
//   status_too_short         one-cycle pulse: frame ended below the minimum
//   status_too_long          one-cycle pulse: frame exceeded the maximum
module axis_frame_len_enforce #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic [LEN_WIDTH-1:0]  cfg_min_len,
  input  logic [LEN_WIDTH-1:0]  cfg_max_len,

  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_frame_len_valid,
  output logic                  status_too_short,
  output logic                  status_too_long
);

  localparam int unsigned CNT_W = LEN_WIDTH + 1;
  localparam logic [CNT_W-1:0] LEN_SAT = {1'b0, {LEN_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DROP
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  min_q, min_d;
  logic [LEN_WIDTH-1:0]  max_q, max_d;

  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;

  logic [LEN_WIDTH-1:0]  st_len_q, st_len_d;
  logic                  st_len_vld_q, st_len_vld_d;
  logic                  st_short_q, st_short_d;
  logic                  st_long_q, st_long_d;

  logic                  s_ready_c;
  logic                  s_fire_c;
  logic [CNT_W-1:0]      beat_bytes_c;
  logic [CNT_W-1:0]      len_c;
  logic [LEN_WIDTH-1:0]  len_sat_c;
  logic [LEN_WIDTH-1:0]  min_c;
  logic [LEN_WIDTH-1:0]  max_c;
  logic                  short_c;
  logic                  over_c;
  logic                  cut_c;

  // Byte count of the current input beat
  always_comb begin
    beat_bytes_c = '0;
    if (KEEP_ENABLE) begin
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
        beat_bytes_c = beat_bytes_c + CNT_W'(s_axis_tkeep[i]);
      end
    end else begin
      beat_bytes_c = CNT_W'(KEEP_WIDTH);
    end
  end

  // Running length and bound checks; the first beat of a frame uses live cfg
  always_comb begin
    min_c     = (state_q == ST_IDLE) ? cfg_min_len : min_q;
    max_c     = (state_q == ST_IDLE) ? cfg_max_len : max_q;
    len_c     = CNT_W'(cnt_q) + beat_bytes_c;
    len_sat_c = (len_c > LEN_SAT) ? {LEN_WIDTH{1'b1}} : len_c[LEN_WIDTH-1:0];
    short_c   = (min_c != '0) && (len_c < CNT_W'(min_c));
    over_c    = (max_c != '0) && (len_c > CNT_W'(max_c));
    // A non-last beat that reaches max guarantees the frame exceeds it, so the
    // cut lands here and the forwarded part never grows past max on beat boundaries.
    cut_c     = (max_c != '0) && (len_c >= CNT_W'(max_c)) && !s_axis_tlast;
  end

  assign s_ready_c     = (state_q == ST_DROP) || m_axis_tready || !tvalid_q;
  assign s_fire_c      = s_axis_tvalid && s_ready_c;
  assign s_axis_tready = s_ready_c;

  // Next-state, output register and status logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    min_d        = min_q;
    max_d        = max_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tvalid_d     = tvalid_q && !m_axis_tready;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    st_len_d     = st_len_q;
    st_len_vld_d = 1'b0;
    st_short_d   = 1'b0;
    st_long_d    = 1'b0;

    if (s_fire_c) begin
      case (state_q)
        ST_IDLE, ST_ACTIVE: begin
          if (state_q == ST_IDLE) begin
            min_d = cfg_min_len;
            max_d = cfg_max_len;
          end
          tvalid_d = 1'b1;
          tdata_d  = s_axis_tdata;
          tkeep_d  = s_axis_tkeep;
          tlast_d  = s_axis_tlast;
          tuser_d  = s_axis_tuser;
          if (s_axis_tlast) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            st_len_d     = len_sat_c;
            st_len_vld_d = 1'b1;
            // Short wins when min > max makes both conditions true
            if (short_c) begin
              tuser_d[0] = 1'b1;
              st_short_d = 1'b1;
            end else if (over_c) begin
              tuser_d[0] = 1'b1;
              st_long_d  = 1'b1;
            end
          end else if (cut_c) begin
            state_d    = ST_DROP;
            cnt_d      = len_sat_c;
            tlast_d    = 1'b1;
            tuser_d[0] = 1'b1;
            st_long_d  = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
            cnt_d   = len_sat_c;
          end
        end
        ST_DROP: begin
          if (s_axis_tlast) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            st_len_d     = len_sat_c;
            st_len_vld_d = 1'b1;
          end else begin
            cnt_d = len_sat_c;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= '0;
      st_len_q     <= '0;
      st_len_vld_q <= 1'b0;
      st_short_q   <= 1'b0;
      st_long_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      st_len_q     <= st_len_d;
      st_len_vld_q <= st_len_vld_d;
      st_short_q   <= st_short_d;
      st_long_q    <= st_long_d;
    end
  end

  assign m_axis_tdata           = tdata_q;
  assign m_axis_tkeep           = tkeep_q;
  assign m_axis_tvalid          = tvalid_q;
  assign m_axis_tlast           = tlast_q;
  assign m_axis_tuser           = tuser_q;
  assign status_frame_len       = st_len_q;
  assign status_frame_len_valid = st_len_vld_q;
  assign status_too_short       = st_short_q;
  assign status_too_long        = st_long_q;

endmodule

// File: tb/tb_axis_frame_len_enforce.sv
`timescale 1ns/1ps
// Bench for axis_frame_len_enforce: an 8-bit instance (no tkeep) and a 32-bit
// instance (tkeep) run side by side against a frame-level reference model.
module tb_axis_frame_len_enforce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cfg_min = '0;
  logic [15:0] cfg_max = '0;

  // 8-bit instance
  logic [7:0]  s0_data = '0;
  logic        s0_keep = 1'b1;
  logic        s0_valid = 1'b0, s0_last = 1'b0, s0_user = 1'b0;
  logic        s0_ready;
  logic [7:0]  m0_data;
  logic        m0_keep, m0_valid, m0_last, m0_user;
  logic        m0_ready = 1'b1;
  logic [15:0] st0_len;
  logic        st0_lv, st0_sh, st0_lg;

  // 32-bit instance
  logic [31:0] s1_data = '0;
  logic [3:0]  s1_keep = 4'hF;
  logic        s1_valid = 1'b0, s1_last = 1'b0, s1_user = 1'b0;
  logic        s1_ready;
  logic [31:0] m1_data;
  logic [3:0]  m1_keep;
  logic        m1_valid, m1_last, m1_user;
  logic        m1_ready = 1'b1;
  logic [15:0] st1_len;
  logic        st1_lv, st1_sh, st1_lg;

  axis_frame_len_enforce #(.DATA_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s0_data), .s_axis_tkeep(s0_keep), .s_axis_tvalid(s0_valid),
    .s_axis_tready(s0_ready), .s_axis_tlast(s0_last), .s_axis_tuser(s0_user),
    .m_axis_tdata(m0_data), .m_axis_tkeep(m0_keep), .m_axis_tvalid(m0_valid),
    .m_axis_tready(m0_ready), .m_axis_tlast(m0_last), .m_axis_tuser(m0_user),
    .cfg_min_len(cfg_min), .cfg_max_len(cfg_max),
    .status_frame_len(st0_len), .status_frame_len_valid(st0_lv),
    .status_too_short(st0_sh), .status_too_long(st0_lg)
  );

  axis_frame_len_enforce #(.DATA_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_data), .s_axis_tkeep(s1_keep), .s_axis_tvalid(s1_valid),
    .s_axis_tready(s1_ready), .s_axis_tlast(s1_last), .s_axis_tuser(s1_user),
    .m_axis_tdata(m1_data), .m_axis_tkeep(m1_keep), .m_axis_tvalid(m1_valid),
    .m_axis_tready(m1_ready), .m_axis_tlast(m1_last), .m_axis_tuser(m1_user),
    .cfg_min_len(cfg_min), .cfg_max_len(cfg_max),
    .status_frame_len(st1_len), .status_frame_len_valid(st1_lv),
    .status_too_short(st1_sh), .status_too_long(st1_lg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: the 32-bit sink can be made to stall randomly
  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    m1_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference model: one pending output beat per instance, frame length counted
  // as an unbounded integer and only saturated when reported.
  bit          slot_full [2] = '{1'b0, 1'b0};
  logic [31:0] slot_d    [2];
  logic [3:0]  slot_k    [2];
  logic        slot_l    [2];
  logic        slot_u    [2];
  bit          in_frame  [2] = '{1'b0, 1'b0};
  bit          dropping  [2] = '{1'b0, 1'b0};
  longint      fbytes    [2] = '{0, 0};
  longint      fmin      [2] = '{0, 0};
  longint      fmax      [2] = '{0, 0};
  bit          e_lv      [2] = '{1'b0, 1'b0};
  bit          e_sh      [2] = '{1'b0, 1'b0};
  bit          e_lg      [2] = '{1'b0, 1'b0};
  longint      e_len     [2] = '{0, 0};

  // Observations of the DUT, compared against literals per test
  int          ob_beats  [2] = '{0, 0};
  int          ob_bad    [2] = '{0, 0};
  int          ob_lv     [2] = '{0, 0};
  int          ob_sh     [2] = '{0, 0};
  int          ob_lg     [2] = '{0, 0};
  logic [15:0] ob_len    [2] = '{16'h0, 16'h0};

  task automatic model_step(input int i, input logic r,
                            input logic sv, input logic sr, input logic [31:0] sd,
                            input logic [3:0] sk, input logic sl, input logic su,
                            input logic mv, input logic mr, input logic [31:0] md,
                            input logic [3:0] mk, input logic ml, input logic mu,
                            input logic [15:0] slen, input logic slv,
                            input logic ssh, input logic slg);
    string p;
    bit nlv, nsh, nlg, under, over, cut;
    p = (i == 0) ? "dw8" : "dw32";

    chk({p, ".m_tvalid"}, 64'(mv), 64'(slot_full[i]));
    chk({p, ".s_tready"}, 64'(sr), 64'(dropping[i] | mr | !slot_full[i]));
    if (slot_full[i]) begin
      chk({p, ".m_tdata"}, 64'(md), 64'(slot_d[i]));
      chk({p, ".m_tkeep"}, 64'(mk), 64'(slot_k[i]));
      chk({p, ".m_tlast"}, 64'(ml), 64'(slot_l[i]));
      chk({p, ".m_tuser"}, 64'(mu), 64'(slot_u[i]));
    end
    chk({p, ".len_valid"}, 64'(slv), 64'(e_lv[i]));
    chk({p, ".too_short"}, 64'(ssh), 64'(e_sh[i]));
    chk({p, ".too_long"}, 64'(slg), 64'(e_lg[i]));
    chk({p, ".frame_len"}, 64'(slen), 64'(e_len[i]));

    if (mv && mr) begin
      ob_beats[i]++;
      if (ml && mu) ob_bad[i]++;
    end
    if (slv) begin
      ob_lv[i]++;
      ob_len[i] = slen;
    end
    if (ssh) ob_sh[i]++;
    if (slg) ob_lg[i]++;

    if (r) begin
      slot_full[i] = 1'b0; in_frame[i] = 1'b0; dropping[i] = 1'b0; fbytes[i] = 0;
      e_lv[i] = 1'b0; e_sh[i] = 1'b0; e_lg[i] = 1'b0; e_len[i] = 0;
      return;
    end

    nlv = 1'b0; nsh = 1'b0; nlg = 1'b0;
    if (mv && mr) slot_full[i] = 1'b0;
    if (sv && sr) begin
      if (!in_frame[i]) begin
        in_frame[i] = 1'b1;
        fbytes[i]   = 0;
        fmin[i]     = longint'(cfg_min);
        fmax[i]     = longint'(cfg_max);
      end
      fbytes[i] += (i == 0) ? 1 : $countones(sk);
      under = (fmin[i] != 0) && (fbytes[i] < fmin[i]);
      over  = (fmax[i] != 0) && (fbytes[i] > fmax[i]);
      cut   = (fmax[i] != 0) && (fbytes[i] >= fmax[i]) && !sl;
      if (!dropping[i]) begin
        slot_full[i] = 1'b1;
        slot_d[i] = sd; slot_k[i] = sk; slot_l[i] = sl; slot_u[i] = su;
        if (sl && under) begin
          slot_u[i] = 1'b1; nsh = 1'b1;
        end else if (sl && over) begin
          slot_u[i] = 1'b1; nlg = 1'b1;
        end else if (cut) begin
          slot_l[i] = 1'b1; slot_u[i] = 1'b1; nlg = 1'b1; dropping[i] = 1'b1;
        end
      end
      if (sl) begin
        nlv = 1'b1;
        e_len[i] = (fbytes[i] > 65535) ? 65535 : fbytes[i];
        in_frame[i] = 1'b0;
        dropping[i] = 1'b0;
      end
    end
    e_lv[i] = nlv; e_sh[i] = nsh; e_lg[i] = nlg;
  endtask

  // Compare process: outputs and inputs are stable at the falling edge
  always @(negedge clk) begin
    model_step(0, rst, s0_valid, s0_ready, {24'h0, s0_data}, {3'b0, s0_keep}, s0_last, s0_user,
               m0_valid, m0_ready, {24'h0, m0_data}, {3'b0, m0_keep}, m0_last, m0_user,
               st0_len, st0_lv, st0_sh, st0_lg);
    model_step(1, rst, s1_valid, s1_ready, s1_data, s1_keep, s1_last, s1_user,
               m1_valid, m1_ready, m1_data, m1_keep, m1_last, m1_user,
               st1_len, st1_lv, st1_sh, st1_lg);
  end

  // Driver: present one beat and hold it until accepted
  task automatic send_beat(input int i, input logic [31:0] d, input logic [3:0] k,
                           input logic l, input logic u);
    bit done;
    done = 1'b0;
    if (i == 0) begin
      s0_data = d[7:0]; s0_keep = 1'b1; s0_last = l; s0_user = u; s0_valid = 1'b1;
    end else begin
      s1_data = d; s1_keep = k; s1_last = l; s1_user = u; s1_valid = 1'b1;
    end
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      done = (i == 0) ? s0_ready : s1_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      errors++;
      $display("FAIL handshake_timeout dw%0d: beat not accepted within 1000 cycles", (i == 0) ? 8 : 32);
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] base, input int n, input bit end_frame);
    for (int b = 0; b < n; b++)
      send_beat(0, 32'(base) + 32'(b), 4'h1, end_frame && (b == n - 1), 1'b0);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #2;
  endtask

  int sb [2], slv [2], ssh [2], slg [2], sbad [2];

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      sb[i] = ob_beats[i]; slv[i] = ob_lv[i]; ssh[i] = ob_sh[i];
      slg[i] = ob_lg[i]; sbad[i] = ob_bad[i];
    end
  endtask

  task automatic chk_frame(input int i, input string name, input int eb, input int elv,
                           input int elen, input int esh, input int elg, input int ebad);
    chk({name, ".beats_out"}, 64'(ob_beats[i] - sb[i]), 64'(eb));
    chk({name, ".len_pulses"}, 64'(ob_lv[i] - slv[i]), 64'(elv));
    chk({name, ".short_pulses"}, 64'(ob_sh[i] - ssh[i]), 64'(esh));
    chk({name, ".long_pulses"}, 64'(ob_lg[i] - slg[i]), 64'(elg));
    chk({name, ".marked_last"}, 64'(ob_bad[i] - sbad[i]), 64'(ebad));
    chk({name, ".reported_len"}, 64'(ob_len[i]), 64'(elen));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("reset.dw8_tvalid", 64'(m0_valid), 64'(0));
    chk("reset.dw32_tvalid", 64'(m1_valid), 64'(0));
    chk("reset.dw8_len", 64'(st0_len), 64'(0));
    chk("reset.dw32_status", 64'({st1_len, st1_lv, st1_sh, st1_lg}), 64'(0));

    // T1: 6-byte legal frame
    cfg_min = 16'd4; cfg_max = 16'd8; snap();
    send_bytes(8'h10, 6, 1'b1); settle();
    chk_frame(0, "t1", 6, 1, 6, 0, 0, 0);

    // T2: 2-byte frame under min
    snap();
    send_bytes(8'h20, 2, 1'b1); settle();
    chk_frame(0, "t2", 2, 1, 2, 1, 0, 1);

    // Single-beat frame, checked on its only beat
    snap();
    send_bytes(8'h28, 1, 1'b1); settle();
    chk_frame(0, "single", 1, 1, 1, 1, 0, 1);

    // T3: 12-byte frame cut at 8
    snap();
    send_bytes(8'h30, 12, 1'b1); settle();
    chk_frame(0, "t3", 8, 1, 12, 0, 1, 1);

    // Exactly max bytes: legal
    snap();
    send_bytes(8'h40, 8, 1'b1); settle();
    chk_frame(0, "at_max", 8, 1, 8, 0, 0, 0);

    // cfg change mid-frame is ignored until the next frame
    cfg_min = 16'd0; cfg_max = 16'd4; snap();
    send_bytes(8'h48, 2, 1'b0);
    cfg_max = 16'd0;
    send_bytes(8'h4A, 4, 1'b1); settle();
    chk_frame(0, "cfg_mid", 4, 1, 6, 0, 1, 1);

    // T5: reset on beat 3 of a 5-beat frame, then a 3-byte frame
    cfg_min = 16'd2; cfg_max = 16'd8; snap();
    send_bytes(8'h51, 2, 1'b0);
    s0_data = 8'h53; s0_last = 1'b0; s0_user = 1'b0; s0_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; s0_valid = 1'b0;
    send_bytes(8'h61, 3, 1'b1); settle();
    chk_frame(0, "t5", 5, 1, 3, 0, 0, 0);

    // T4: 32-bit beats with tkeep, random downstream stalls
    rand_rdy = 1'b1;
    cfg_min = 16'd4; cfg_max = 16'd64; snap();
    for (int f = 0; f < 3; f++) begin
      send_beat(1, 32'hA000_0000 + 32'(f * 16), 4'hF, 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      send_beat(1, 32'hA000_0001 + 32'(f * 16), 4'hF, 1'b0, 1'b0);
      send_beat(1, 32'hA000_0002 + 32'(f * 16), 4'h3, 1'b1, 1'b0);
    end
    settle();
    chk_frame(1, "t4", 9, 3, 10, 0, 0, 0);

    // Length exactly at min and max
    cfg_min = 16'd8; cfg_max = 16'd8; snap();
    send_beat(1, 32'hB000_0000, 4'hF, 1'b0, 1'b0);
    send_beat(1, 32'hB000_0001, 4'hF, 1'b1, 1'b0); settle();
    chk_frame(1, "edge8", 2, 1, 8, 0, 0, 0);

    // 13-byte frame cut when the count reaches max=8
    cfg_min = 16'd0; cfg_max = 16'd8; snap();
    send_beat(1, 32'hC000_0000, 4'hF, 1'b0, 1'b0);
    send_beat(1, 32'hC000_0001, 4'hF, 1'b0, 1'b0);
    send_beat(1, 32'hC000_0002, 4'hF, 1'b0, 1'b0);
    send_beat(1, 32'hC000_0003, 4'h1, 1'b1, 1'b0); settle();
    chk_frame(1, "cut32", 2, 1, 13, 0, 1, 1);

    // min > max: short check wins at tlast
    cfg_min = 16'd10; cfg_max = 16'd3; snap();
    send_beat(1, 32'hD000_0000, 4'hF, 1'b1, 1'b0); settle();
    chk_frame(1, "min_gt_max", 1, 1, 4, 1, 0, 1);

    // Input bad marker passes through without an error pulse
    cfg_min = 16'd0; cfg_max = 16'd0; snap();
    send_beat(1, 32'hE000_0000, 4'hF, 1'b0, 1'b0);
    send_beat(1, 32'hE000_0001, 4'h3, 1'b1, 1'b1); settle();
    chk_frame(1, "user_in", 2, 1, 6, 0, 0, 1);

    // T6: 70000-byte frame, no bounds, length saturates
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1; snap();
    for (int b = 0; b < 17500; b++)
      send_beat(1, 32'(b) ^ 32'h5A5A_0000, 4'hF, b == 17499, 1'b0);
    settle();
    chk_frame(1, "t6", 17500, 1, 16'hFFFF, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
